// File: rtl/water_valve_arbiter.sv
// Round-robin arbiter granting one washing machine at a time access to a shared inlet valve.
// Optional fill timeout enabled by defining WATER_TIMEOUT_EN.
module water_valve_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_FILL = 64,
  parameter int unsigned GAP      = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] I_REQ,
  input  logic [N-1:0] I_REL,
  input  logic [N-1:0] I_LID,
  output logic [N-1:0] O_GNT,
  output logic         O_VALVE,
  output logic         O_BUSY,
  output logic [N-1:0] O_TOUT
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FW = $clog2(MAX_FILL + 1);
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {IDLE, GRANT, PAUSE, SETTLE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_d;
  logic            valve_d;
  logic [N-1:0]    tout_q, tout_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [N-1:0]    elig;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   ptr_nxt;
  logic [FW-1:0]   fill_inc;
  logic            rel;

  assign elig     = I_REQ & ~I_LID & ~tout_q;
  assign ptr_nxt  = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);
  assign fill_inc = fill_q + FW'(1);
  assign rel      = I_REL[gidx_q] | ~I_REQ[gidx_q];
  assign O_TOUT   = tout_q;

  // First eligible index at or above the pointer, wrapping; lowest offset wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx  = '0;
    pick = ptr_q;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % int'(N));
      if (elig[idx]) pick = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = O_GNT;
    valve_d = 1'b0;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    fill_d  = fill_q;
    scnt_d  = scnt_q;
`ifdef WATER_TIMEOUT_EN
    tout_d  = tout_q & I_REQ;
`else
    tout_d  = '0;
`endif

    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d     = GRANT;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          gidx_d      = pick;
          valve_d     = 1'b1;
          fill_d      = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = SETTLE;
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
          fill_d  = '0;
          scnt_d  = '0;
`ifdef WATER_TIMEOUT_EN
        end else if (fill_inc == FW'(MAX_FILL)) begin
          state_d        = SETTLE;
          gnt_d          = '0;
          ptr_d          = ptr_nxt;
          fill_d         = '0;
          scnt_d         = '0;
          tout_d[gidx_q] = 1'b1;
`endif
        end else if (I_LID[gidx_q]) begin
          state_d = PAUSE;
          fill_d  = fill_inc;
        end else begin
          valve_d = 1'b1;
          fill_d  = fill_inc;
        end
      end
      PAUSE: begin
        // Release beats a still-open lid; the fill count stays frozen here.
        if (rel) begin
          state_d = SETTLE;
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
          fill_d  = '0;
          scnt_d  = '0;
        end else if (!I_LID[gidx_q]) begin
          state_d = GRANT;
          valve_d = 1'b1;
        end
      end
      SETTLE: begin
        gnt_d = '0;
        if (scnt_q == SW'(GAP - 1)) begin
          state_d = IDLE;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      O_GNT   <= '0;
      O_VALVE <= 1'b0;
      O_BUSY  <= 1'b0;
      tout_q  <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      fill_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      O_GNT   <= gnt_d;
      O_VALVE <= valve_d;
      O_BUSY  <= (state_d != IDLE);
      tout_q  <= tout_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      fill_q  <= fill_d;
      scnt_q  <= scnt_d;
    end
  end

endmodule

// File: tb/tb_water_valve_arbiter.sv
// Table-driven bench for water_valve_arbiter: each row drives one clock of inputs and
// lists the outputs expected just after that edge (N=4, GAP=2, MAX_FILL=8).
module tb_water_valve_arbiter;

  logic       CLK;
  logic       RST;
  logic [3:0] I_REQ, I_REL, I_LID;
  logic [3:0] O_GNT, O_TOUT;
  logic       O_VALVE, O_BUSY;

  typedef struct {
    int         sc;
    logic       rst;
    logic [3:0] req, rel, lid;
    logic [3:0] gnt;
    logic       valve, busy;
    logic [3:0] tout;
  } vec_t;

  vec_t  tbl[$];
  int    checks = 0;
  int    passes = 0;
  int    cur_sc = 0;
  string names[6] = '{"basic", "round_robin", "lid_pause", "corners", "reset_mid", "timeout"};

  water_valve_arbiter #(.N(4), .MAX_FILL(8), .GAP(2)) dut (
    .CLK(CLK), .RST(RST), .I_REQ(I_REQ), .I_REL(I_REL), .I_LID(I_LID),
    .O_GNT(O_GNT), .O_VALVE(O_VALVE), .O_BUSY(O_BUSY), .O_TOUT(O_TOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] rel,
                              input logic [3:0] lid, input logic [3:0] gnt, input logic valve,
                              input logic busy, input logic [3:0] tout);
    vec_t v;
    v.sc = cur_sc; v.rst = rst; v.req = req; v.rel = rel; v.lid = lid;
    v.gnt = gnt; v.valve = valve; v.busy = busy; v.tout = tout;
    tbl.push_back(v);
  endfunction

  task automatic run_row(input vec_t v, input int idx);
    RST = v.rst; I_REQ = v.req; I_REL = v.rel; I_LID = v.lid;
    @(posedge CLK);
    #1;
    checks++;
    if ({O_GNT, O_VALVE, O_BUSY, O_TOUT} === {v.gnt, v.valve, v.busy, v.tout})
      passes++;
    else
      $display("FAIL %s row %0d: got gnt=%b valve=%b busy=%b tout=%b, want gnt=%b valve=%b busy=%b tout=%b",
               names[v.sc], idx, O_GNT, O_VALVE, O_BUSY, O_TOUT, v.gnt, v.valve, v.busy, v.tout);
  endtask

  initial begin
    int         order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] oh;

    // basic: one grant of five open cycles, then a pointer-advanced grant
    cur_sc = 0;
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++) add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 1, 4'b0000);
    add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);

    // round_robin: all request, each holds three cycles, order 0,1,2,3,0
    cur_sc = 1;
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << order[j];
      for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b0000, 4'b0000, oh, 1, 1, 4'b0000);
      add(0, 4'b1111, oh,      4'b0000, 4'b0000, 0, 1, 4'b0000);
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    end

    // lid_pause: machine 2 paused ten cycles while others request
    cur_sc = 2;
    add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 1, 4'b0000);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 1, 4'b0000);
    for (int i = 0; i < 10; i++) add(0, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 0, 1, 4'b0000);
    for (int i = 0; i < 3; i++)  add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 1, 4'b0000);
    add(0, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);

    // corners: lid makes ineligible, release+lid same edge, release during pause
    cur_sc = 3;
    add(0, 4'b0011, 4'b0000, 4'b0001, 4'b0010, 1, 1, 4'b0000);
    add(0, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1, 1, 4'b0000);
    add(0, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 0, 1, 4'b0000);
    add(0, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0000);

    // reset_mid: reset while machine 1 fills clears pointer back to 0
    cur_sc = 4;
    add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0000);
    add(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);

    // timeout: machine 1 never releases
    cur_sc = 5;
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int i = 0; i < 8; i++) add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0000);
`ifdef WATER_TIMEOUT_EN
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0010);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0010);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0010);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0000);
    for (int i = 0; i < 7; i++) add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0000);
    // release on the edge the count would expire: no timeout flag
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 1, 4'b0000);
`else
    for (int i = 0; i < 6; i++) add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0000);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 1, 4'b0000);
`endif
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
